// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative write-allocate data cache:
// geometry, address-field helpers, line type and controller state encoding.
// Optional build macro CACHE_WRITE_THROUGH_EN adds the ST_WT_WRITE state.
package cache_pkg;

  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int NUM_SETS       = 4;

  localparam int BYTE_W     = 2;
  localparam int WORD_SEL_W = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_W   = BYTE_W + WORD_SEL_W;
  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int TAG_W      = ADDR_W - OFFSET_W - INDEX_W;
  localparam int LINE_W     = DATA_W * WORDS_PER_LINE;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [LINE_W-1:0]     line_t;
  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [INDEX_W-1:0]    index_t;
  typedef logic [WORD_SEL_W-1:0] word_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_ALLOCATE  = 3'd3
`ifdef CACHE_WRITE_THROUGH_EN
    ,
    ST_WT_WRITE  = 3'd4
`endif
  } state_t;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic index_t addr_index(input addr_t a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic word_sel_t addr_word(input addr_t a);
    return a[BYTE_W +: WORD_SEL_W];
  endfunction

  // Line-aligned memory address built from a tag and a set index.
  function automatic addr_t line_addr(input tag_t t, input index_t i);
    return {t, i, {OFFSET_W{1'b0}}};
  endfunction

  function automatic word_t get_word(input line_t line, input word_sel_t sel);
    return line[int'(sel) * DATA_W +: DATA_W];
  endfunction

  function automatic line_t put_word(input line_t line, input word_sel_t sel,
                                     input word_t w);
    line_t r;
    r = line;
    r[int'(sel) * DATA_W +: DATA_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid/dirty/tag bits and line storage.
// Reads are combinational at i_index; a fill writes a whole line, a store
// writes one word. With CACHE_WRITE_THROUGH_EN the dirty bit is tied to 0.
module cache_way_array
  import cache_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  index_t    i_index,
  input  logic      i_fill_we,
  input  tag_t      i_fill_tag,
  input  line_t     i_fill_line,
  input  logic      i_word_we,
  input  word_sel_t i_word_sel,
  input  word_t     i_word_data,
  output logic      o_valid,
  output logic      o_dirty,
  output tag_t      o_tag,
  output line_t     o_line
);

  logic [NUM_SETS-1:0] r_valid;
  tag_t                r_tag  [NUM_SETS];
  line_t               r_data [NUM_SETS];

  // Valid bits: cleared by reset, set when a line is filled from memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_fill_we) begin
      r_valid[i_index] <= 1'b1;
    end
  end

`ifndef CACHE_WRITE_THROUGH_EN
  logic [NUM_SETS-1:0] r_dirty;

  // Dirty bits: a fresh fill is clean, any store marks the line dirty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_dirty[i_index] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  assign o_dirty = r_dirty[i_index];
`else
  assign o_dirty = 1'b0;
`endif

  // Tag and line storage; contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_tag[i_index]  <= i_fill_tag;
      r_data[i_index] <= i_fill_line;
    end else if (i_word_we) begin
      r_data[i_index] <= put_word(r_data[i_index], i_word_sel, i_word_data);
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_line  = r_data[i_index];

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for a 2-way set-associative write-allocate data cache.
// Latches one CPU access, looks it up in both ways, and on a miss writes back
// a dirty victim and fetches the line over the mem_req/mem_ready handshake.
// Build macro CACHE_WRITE_THROUGH_EN: stores also write the updated line to
// memory (ST_WT_WRITE) and lines never become dirty.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_read_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_miss;
  logic                r_victim;
  logic [NUM_SETS-1:0] r_lru;

  logic  r_req_rw;
  addr_t r_req_addr;
  word_t r_req_wdata;

  index_t    w_index;
  tag_t      w_tag;
  word_sel_t w_word;

  logic [1:0] w_valid;
  logic [1:0] w_dirty;
  tag_t       w_way_tag  [2];
  line_t      w_way_line [2];

  logic       w_hit0;
  logic       w_hit1;
  logic       w_hit;
  logic       w_hit_way;
  logic       w_victim;
  logic       w_accept;
  logic       w_set_miss;
  logic       w_lru_upd;
  logic [1:0] w_fill_we;
  logic [1:0] w_word_we;

  assign w_index  = addr_index(r_req_addr);
  assign w_tag    = addr_tag(r_req_addr);
  assign w_word   = addr_word(r_req_addr);
  assign w_accept = (r_state == ST_IDLE) && cpu_req;

  assign w_hit0    = w_valid[0] && (w_way_tag[0] == w_tag);
  assign w_hit1    = w_valid[1] && (w_way_tag[1] == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = w_hit1 && !w_hit0;

  // Prefer an invalid way (way 0 first), otherwise replace the LRU way.
  assign w_victim = !w_valid[0] ? 1'b0 :
                    !w_valid[1] ? 1'b1 : r_lru[w_index];

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way_array u_way (
      .clk         (clk),
      .reset       (reset),
      .i_index     (w_index),
      .i_fill_we   (w_fill_we[g]),
      .i_fill_tag  (w_tag),
      .i_fill_line (mem_rdata),
      .i_word_we   (w_word_we[g]),
      .i_word_sel  (w_word),
      .i_word_data (r_req_wdata),
      .o_valid     (w_valid[g]),
      .o_dirty     (w_dirty[g]),
      .o_tag       (w_way_tag[g]),
      .o_line      (w_way_line[g])
    );
  end

`ifdef CACHE_WRITE_THROUGH_EN
  logic r_way;
`endif

  // Control state: FSM register, miss flag, victim choice and LRU bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_miss   <= 1'b0;
      r_victim <= 1'b0;
      r_lru    <= '0;
`ifdef CACHE_WRITE_THROUGH_EN
      r_way    <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_miss <= 1'b0;
      end
      if (w_set_miss) begin
        r_miss   <= 1'b1;
        r_victim <= w_victim;
      end
      if (w_lru_upd) begin
        r_lru[w_index] <= ~w_hit_way;
`ifdef CACHE_WRITE_THROUGH_EN
        r_way          <= w_hit_way;
`endif
      end
    end
  end

  // Capture the CPU access when it is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req_rw    <= cpu_read_write;
      r_req_addr  <= cpu_address;
      r_req_wdata <= cpu_write_data;
    end
  end

  // Next-state logic and all controller outputs; everything idles at 0.
  always_comb begin
    w_next_state  = r_state;
    cpu_ready     = 1'b0;
    cpu_read_data = '0;
    cpu_hit       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    w_fill_we     = 2'b00;
    w_word_we     = 2'b00;
    w_set_miss    = 1'b0;
    w_lru_upd     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          w_next_state = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (w_hit) begin
          w_lru_upd = 1'b1;
          if (r_req_rw) begin
            w_word_we[w_hit_way] = 1'b1;
`ifdef CACHE_WRITE_THROUGH_EN
            w_next_state = ST_WT_WRITE;
`else
            cpu_ready    = 1'b1;
            cpu_hit      = ~r_miss;
            w_next_state = ST_IDLE;
`endif
          end else begin
            cpu_ready     = 1'b1;
            cpu_hit       = ~r_miss;
            cpu_read_data = get_word(w_way_line[w_hit_way], w_word);
            w_next_state  = ST_IDLE;
          end
        end else begin
          w_set_miss = 1'b1;
          if (w_valid[w_victim] && w_dirty[w_victim]) begin
            w_next_state = ST_WRITEBACK;
          end else begin
            w_next_state = ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(w_way_tag[r_victim], w_index);
        mem_wdata = w_way_line[r_victim];
        if (mem_ready) begin
          w_next_state = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(w_tag, w_index);
        if (mem_ready) begin
          w_fill_we[r_victim] = 1'b1;
          w_next_state        = ST_COMPARE;
        end
      end
`ifdef CACHE_WRITE_THROUGH_EN
      ST_WT_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(w_tag, w_index);
        mem_wdata = w_way_line[r_way];
        if (mem_ready) begin
          cpu_ready    = 1'b1;
          cpu_hit      = ~r_miss;
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a vector table of CPU accesses
// with expected results and memory traffic, a scoreboard queue of expected
// responses, a latency-programmable memory model, and hand-written sequences
// for stray mem_ready and asynchronous reset in the middle of a fill.
module tb_cache_controller;
  import cache_pkg::*;

`ifdef CACHE_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_read_write = 1'b0;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic [DATA_W-1:0] cpu_write_data = '0;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cpu_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  logic        r_mdl_ready = 1'b0;
  logic        r_stray = 1'b0;
  logic [LINE_W-1:0] mem [64];
  int          mem_lat = 1;
  int          n_rd = 0, n_wr = 0, op_seq = 0, rd_seq = 0, wr_seq = 0;
  logic [9:0]  rd_addr = '0, wr_addr = '0;
  logic [31:0] wr_w0 = '0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic        rw;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_data;
    int          exp_rd;
    logic [9:0]  exp_rd_addr;
    int          exp_wr;
    logic [9:0]  exp_wr_addr;
    logic [31:0] exp_wr_w0;
    int          exp_lat;
    logic [31:0] exp_mem0;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic        rw;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[11];

  assign mem_ready = r_mdl_ready | r_stray;
  assign mem_rdata = mem[mem_addr[9:4]];

  always #5 clk = ~clk;

  cache_controller dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_read_write (cpu_read_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_ready      (cpu_ready),
    .cpu_read_data  (cpu_read_data),
    .cpu_hit        (cpu_hit),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
  );

  // Memory model: line 0 all zero, line k word w = A000_0000 | k<<8 | w.
  // Answers mem_req after mem_lat cycles with a one-cycle mem_ready.
  initial begin
    int cnt;
    cnt = 0;
    for (int k = 0; k < 64; k++)
      for (int w = 0; w < 4; w++)
        mem[k][w*32 +: 32] = (k == 0) ? 32'h0 : (32'hA000_0000 | (k << 8) | w);
    forever begin
      @(negedge clk);
      if (reset) begin
        r_mdl_ready = 1'b0;
        cnt = 0;
      end else if (r_mdl_ready) begin
        r_mdl_ready = 1'b0;
      end else if (mem_req) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          r_mdl_ready = 1'b1;
          op_seq++;
          if (mem_we) begin
            n_wr++;
            wr_seq  = op_seq;
            wr_addr = mem_addr;
            wr_w0   = mem_wdata[31:0];
            mem[mem_addr[9:4]] = mem_wdata;
          end else begin
            n_rd++;
            rd_seq  = op_seq;
            rd_addr = mem_addr;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  lat;
    bit  seen;
    int  rd0, wr0;
    sb_t e;
    @(negedge clk);
    sb.push_back('{v.exp_hit, v.exp_data, v.rw});
    rd0 = n_rd;
    wr0 = n_wr;
    cpu_req        = 1'b1;
    cpu_read_write = v.rw;
    cpu_address    = v.addr;
    cpu_write_data = v.wdata;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (cpu_ready) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s timeout: no cpu_ready within 100 cycles", tag);
      void'(sb.pop_front());
      cpu_req = 1'b0;
      return;
    end
    e = sb.pop_front();
    check({tag, " cpu_hit"}, cpu_hit, e.hit);
    if (!e.rw) check({tag, " read_data"}, cpu_read_data, e.data);
    cpu_req = 1'b0;
    check({tag, " mem reads"}, n_rd - rd0, v.exp_rd);
    check({tag, " mem writes"}, n_wr - wr0, v.exp_wr);
    if (v.exp_rd > 0) check({tag, " read addr"}, rd_addr, v.exp_rd_addr);
    if (v.exp_wr > 0) begin
      check({tag, " write addr"}, wr_addr, v.exp_wr_addr);
      check({tag, " write word0"}, wr_w0, v.exp_wr_w0);
    end
    if (v.exp_rd > 0 && v.exp_wr > 0) check({tag, " writeback before fill"}, wr_seq < rd_seq, 1);
    if (v.exp_lat > 0) check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " memory[0]"}, mem[0][31:0], v.exp_mem0);
  endtask

  initial begin
    vec_t p;
    bit   seen;
    // rw addr wdata hit data | rd rd_addr | wr wr_addr wr_w0 | lat mem0
    vecs[0]  = '{0, 10'h000, 32'h0, 0, 32'h0,
                 1, 10'h000, 0, 10'h0, 32'h0, 0, 32'h0};
    vecs[1]  = '{1, 10'h000, 32'hFF, 1, 32'h0,
                 0, 10'h000, WT ? 1 : 0, 10'h000, 32'hFF, WT ? 0 : 1, WT ? 32'hFF : 32'h0};
    vecs[2]  = '{0, 10'h000, 32'h0, 1, 32'hFF,
                 0, 10'h000, 0, 10'h0, 32'h0, 1, WT ? 32'hFF : 32'h0};
    vecs[3]  = '{0, 10'h200, 32'h0, 0, 32'hA000_2000,
                 1, 10'h200, 0, 10'h0, 32'h0, 0, WT ? 32'hFF : 32'h0};
    vecs[4]  = '{0, 10'h000, 32'h0, 1, 32'hFF,
                 0, 10'h000, 0, 10'h0, 32'h0, 1, WT ? 32'hFF : 32'h0};
    vecs[5]  = '{0, 10'h304, 32'h0, 0, 32'hA000_3001,
                 1, 10'h300, 0, 10'h0, 32'h0, 0, WT ? 32'hFF : 32'h0};
    vecs[6]  = '{0, 10'h200, 32'h0, 0, 32'hA000_2000,
                 1, 10'h200, WT ? 0 : 1, 10'h000, 32'hFF, 0, 32'hFF};
    vecs[7]  = '{0, 10'h01C, 32'h0, 0, 32'hA000_0103,
                 1, 10'h010, 0, 10'h0, 32'h0, 0, 32'hFF};
    vecs[8]  = '{1, 10'h018, 32'h1234_5678, 1, 32'h0,
                 0, 10'h000, WT ? 1 : 0, 10'h010, 32'hA000_0100, WT ? 0 : 1, 32'hFF};
    vecs[9]  = '{0, 10'h018, 32'h0, 1, 32'h1234_5678,
                 0, 10'h000, 0, 10'h0, 32'h0, 1, 32'hFF};
    vecs[10] = '{0, 10'h300, 32'h0, 1, 32'hA000_3000,
                 0, 10'h000, 0, 10'h0, 32'h0, 1, 32'hFF};

    // Reset: outputs must be zero while reset is held.
    #1 reset = 1'b1;
    #1;
    check("reset cpu_ready", cpu_ready, 0);
    check("reset cpu_hit", cpu_hit, 0);
    check("reset cpu_read_data", cpu_read_data, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // mem_ready pulse with no transfer in flight must be ignored.
    @(negedge clk);
    r_stray = 1'b1;
    @(negedge clk);
    r_stray = 1'b0;
    #1;
    check("stray mem_req", mem_req, 0);
    check("stray cpu_ready", cpu_ready, 0);
    p = '{0, 10'h018, 32'h0, 1, 32'h1234_5678, 0, 10'h0, 0, 10'h0, 32'h0, 1, 32'hFF};
    run_vec(p, "after_stray");

    // Reset in the middle of a slow fill: mem_req must fall without a clock.
    mem_lat = 5;
    @(negedge clk);
    cpu_req        = 1'b1;
    cpu_read_write = 1'b0;
    cpu_address    = 10'h000;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (mem_req && !mem_we) seen = 1'b1;
    end
    check("fill started", seen, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset mem_req", mem_req, 0);
    check("async reset cpu_ready", cpu_ready, 0);
    check("async reset mem_addr", mem_addr, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    mem_lat = 1;

    p = '{0, 10'h000, 32'h0, 0, 32'hFF, 1, 10'h000, 0, 10'h0, 32'h0, 0, 32'hFF};
    run_vec(p, "post_reset0");
    p = '{0, 10'h018, 32'h0, 0, WT ? 32'h1234_5678 : 32'hA000_0102,
          1, 10'h010, 0, 10'h0, 32'h0, 0, 32'hFF};
    run_vec(p, "post_reset1");

    check("scoreboard empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for a 2-way set-associative, write-allocate data cache on the 10-bit byte-address memory path.
- Sits between the CPU-side access port (read_write / address / write_data) and the multi-cycle main-memory model.
- Owns tag/valid/dirty/LRU state and the line storage.
- Moves whole 4-word lines to and from memory with a req/ready handshake.
- Write-back by default.

Parameters:
- ADDR_W, 10: byte address width.
- DATA_W, 32: word width.
- WORDS_PER_LINE, 4: words per line (16-byte lines). Offset is bits [3:0]; bits [1:0] are ignored.
- NUM_SETS, 4: sets. Index is bits [5:4]; tag is bits [9:6].

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- cpu_req, in, 1: access request. Must stay high, with inputs stable, until cpu_ready.
- cpu_read_write, in, 1: 0 = read, 1 = write.
- cpu_address, in, ADDR_W: byte address.
- cpu_write_data, in, DATA_W: store data.
- cpu_ready, out, 1: one-cycle pulse; the access is complete.
- cpu_read_data, out, DATA_W: load result; valid while cpu_ready is high.
- cpu_hit, out, 1: 1 if the original lookup hit; valid while cpu_ready is high.
- mem_req, out, 1: memory line transfer request.
- mem_we, out, 1: 1 = line write, 0 = line read.
- mem_addr, out, ADDR_W: line-aligned address (bits [3:0] = 0).
- mem_wdata, out, DATA_W*WORDS_PER_LINE: line being written; word 0 in the LSBs.
- mem_rdata, in, DATA_W*WORDS_PER_LINE: line being read.
- mem_ready, in, 1: one-cycle completion of the current mem_req.

Behaviour:
- Reset values: all valid, dirty and LRU bits cleared; state IDLE; every output 0.
  - Reset is asynchronous, so it drops mem_req immediately, including mid-transfer.
  - Any partially fetched line is discarded.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE (plus WT_WRITE, see Optional Feature).
- IDLE:
  - When cpu_req is high, latch the access and a miss flag of 0, then go to COMPARE.
- COMPARE: look up both ways of the set.
  - Hit: pulse cpu_ready. cpu_hit = NOT miss flag. Update LRU[set] to the way not accessed. Return to IDLE.
  - Read hit: cpu_read_data = the selected word.
  - Write hit: replace the word in the line and set dirty.
  - Miss: set the miss flag and choose a victim.
    - An invalid way is preferred; way 0 if both are invalid; otherwise the LRU way.
    - Victim valid and dirty -> WRITEBACK; otherwise -> ALLOCATE.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={victim tag, index, 4'b0}, mem_wdata=victim line.
  - Hold until mem_ready, then go to ALLOCATE.
- ALLOCATE:
  - Drive mem_req=1, mem_we=0, mem_addr={req tag, index, 4'b0}.
  - On mem_ready, write mem_rdata into the victim way: valid=1, dirty=0, tag updated.
  - Then go to COMPARE, which now hits.
- Latency:
  - Hit: cpu_ready one cycle after the request is accepted.
  - Clean miss: 2 + memory latency.
  - Dirty miss: 2 + two memory latencies.
- Boundary conditions:
  - mem_ready while mem_req is low is ignored.
  - cpu_req dropped mid-miss is a protocol violation; the controller finishes the fill, and cpu_ready is still pulsed.
  - A new request is accepted only in IDLE; back-to-back requests therefore cost one idle cycle.
  - A write miss fetches the line, then performs the write in COMPARE (write-allocate).

Optional Feature:
- Macro: CACHE_WRITE_THROUGH_EN.
- Defined:
  - Dirty bits are unused (tied 0); evictions never enter WRITEBACK.
  - A write hit updates the line, then enters WT_WRITE, which drives mem_req=1, mem_we=1 with the updated line.
  - cpu_ready pulses on mem_ready.
- Undefined: write-back as above; WT_WRITE does not exist.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, DATA_W, WORDS_PER_LINE, NUM_SETS;
  - derived OFFSET_W, INDEX_W, TAG_W;
  - the state enum;
  - a line typedef;
  - address-field slicing functions.
- One sub-module, cache_way_array: a single way's tag/valid/dirty/data storage with read and line/word write ports.
  - Instantiated twice; the LRU bits stay in cache_controller.

Test Plan:
1. Reset, read 0x000 with memory all zero -> one mem read at 0x000 with no WRITEBACK; cpu_hit=0, cpu_read_data=0x00000000.
2. Write 0x000 with 0x000000FF -> cpu_ready one cycle after acceptance, cpu_hit=1, no mem_req; memory[0] stays 0x00. Read 0x000 -> hit, data 0x000000FF.
3. Read 0x200 -> miss that fills way 1. Read 0x000 -> hit.
4. Read 0x300 -> miss that evicts clean 0x200 with no writeback. Read 0x200 -> miss that evicts dirty 0x000: WRITEBACK at mem_addr 0x000 with word 0 = 0xFF, then ALLOCATE at 0x200; afterwards memory[0] = 0xFF.
5. Assert reset mid-ALLOCATE with memory latency 5 -> mem_req drops asynchronously; the next read of 0x000 misses.
6. With CACHE_WRITE_THROUGH_EN: after scenario 1, write 0x000 with 0xFF -> cpu_hit=1, one mem write at 0x000, memory[0] = 0xFF before cpu_ready.
